// File: rtl/chan_responder_if.sv
// ============================================================================
// Module  : chan_responder_if
// Brief   : Bus bundle between a message source/sink and chan_responder.
//           The master side drives the inbound message and bus status; the
//           slave side (chan_responder) returns the outbound message and the
//           buffer status.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

`ifndef CPU_MSG_SIZE0
`define CPU_MSG_SIZE0 3
`endif
`ifndef ADDR_SIZE0
`define ADDR_SIZE0 7
`endif
`ifndef DATA_SIZE0
`define DATA_SIZE0 7
`endif
`ifndef CPU_R_CHAN_SET
`define CPU_R_CHAN_SET 4'd5
`endif
`ifndef CPU_R_CHAN_DONE
`define CPU_R_CHAN_DONE 4'd6
`endif

interface chan_responder_if #(
  parameter int DEPTH = 4
);
  localparam int c_CW = $clog2(DEPTH) + 1;

  // Inbound message and bus status
  logic                    cpu_msg_pulse;
  logic [`CPU_MSG_SIZE0:0] cpu_msg_in;
  logic [`ADDR_SIZE0:0]    addr_in;
  logic [`DATA_SIZE0:0]    data_in;
  logic                    is_bus_busy;
  logic                    disp_online;

  // Outbound message and buffer status
  logic [`CPU_MSG_SIZE0:0] cpu_msg_out;
  logic [`ADDR_SIZE0:0]    addr_out;
  logic [`DATA_SIZE0:0]    data_out;
  logic                    cpu_msg_pulse_o;
  logic                    chan_full;
  logic [c_CW-1:0]         fifo_count;
  logic [7:0]              ovf_cnt;

  modport master (
    output cpu_msg_pulse, cpu_msg_in, addr_in, data_in, is_bus_busy, disp_online,
    input  cpu_msg_out, addr_out, data_out, cpu_msg_pulse_o, chan_full,
           fifo_count, ovf_cnt
  );

  modport slave (
    input  cpu_msg_pulse, cpu_msg_in, addr_in, data_in, is_bus_busy, disp_online,
    output cpu_msg_out, addr_out, data_out, cpu_msg_pulse_o, chan_full,
           fifo_count, ovf_cnt
  );
endinterface

`default_nettype wire

// File: rtl/chan_responder.sv
// ============================================================================
// Module  : chan_responder
// Brief   : Buffers inbound channel-SET messages in a small FIFO and replays
//           each one on the outbound bus as a SET beat followed by a DONE
//           beat, whenever the bus is free and the display is online.
//           All state advances on the falling edge of clk.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module chan_responder #(
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  chan_responder_if.slave  bus
);

  localparam int c_AW      = $clog2(DEPTH);
  localparam int c_CW      = c_AW + 1;
  localparam int c_ADDR_W  = `ADDR_SIZE0 + 1;
  localparam int c_DATA_W  = `DATA_SIZE0 + 1;
  localparam int c_ENTRY_W = c_ADDR_W + c_DATA_W;

  localparam logic [c_CW-1:0] c_DEPTH_CNT = c_CW'(DEPTH);

  // Delivery sequencer states
  localparam logic [1:0] c_IDLE = 2'd0;
  localparam logic [1:0] c_SEND = 2'd1;
  localparam logic [1:0] c_DONE = 2'd2;

  logic [c_ENTRY_W-1:0]     r_mem [DEPTH];
  logic [c_AW-1:0]          r_wptr;
  logic [c_AW-1:0]          r_rptr;
  logic [c_CW-1:0]          r_count;
  logic [7:0]               r_ovf;
  logic [1:0]               r_state;
  logic [`CPU_MSG_SIZE0:0]  r_msg_out;
  logic [`ADDR_SIZE0:0]     r_addr_out;
  logic [`DATA_SIZE0:0]     r_data_out;
  logic                     r_pulse_out;

  logic                     w_full;
  logic                     w_set;
  logic                     w_push;
  logic                     w_drop;
  logic                     w_pop;
  logic [c_ENTRY_W-1:0]     w_head;

  // Fullness comes from the registered count, so a pop on the same edge
  // never makes room for a SET that arrives while full.
  assign w_full = (r_count == c_DEPTH_CNT);
  assign w_set  = bus.cpu_msg_pulse && (bus.cpu_msg_in == `CPU_R_CHAN_SET);
  assign w_push = w_set && !w_full;
  assign w_drop = w_set &&  w_full;
  // The bus status is only consulted while idle; a started delivery always
  // runs its full SEND/DONE sequence.
  assign w_pop  = (r_state == c_IDLE) && (r_count != '0) &&
                  !bus.is_bus_busy && bus.disp_online;
  assign w_head = r_mem[r_rptr];

  // Entry storage: payload only, the pointers and count define validity
  always_ff @(negedge clk) begin
    if (w_push) begin
      r_mem[r_wptr] <= {bus.addr_in, bus.data_in};
    end
  end

  // FIFO pointers, occupancy and dropped-write counter
  always_ff @(negedge clk or posedge rst) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_ovf   <= '0;
    end else begin
      if (w_push) begin
        r_wptr <= r_wptr + 1'b1;
      end
      if (w_pop) begin
        r_rptr <= r_rptr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      if (w_drop && (r_ovf != 8'hFF)) begin
        r_ovf <= r_ovf + 8'd1;
      end
    end
  end

  // Delivery sequencer: IDLE -> SEND (SET beat) -> DONE (DONE beat) -> IDLE
  always_ff @(negedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= c_IDLE;
      r_msg_out   <= '0;
      r_addr_out  <= '0;
      r_data_out  <= '0;
      r_pulse_out <= 1'b0;
    end else begin
      case (r_state)
        c_IDLE: begin
          if (w_pop) begin
            r_state     <= c_SEND;
            r_msg_out   <= `CPU_R_CHAN_SET;
            r_addr_out  <= w_head[c_ENTRY_W-1:c_DATA_W];
            r_data_out  <= w_head[c_DATA_W-1:0];
            r_pulse_out <= 1'b1;
          end else begin
            r_msg_out   <= '0;
            r_addr_out  <= '0;
            r_data_out  <= '0;
            r_pulse_out <= 1'b0;
          end
        end
        c_SEND: begin
          // Address is held so the DONE beat names the same channel
          r_state     <= c_DONE;
          r_msg_out   <= `CPU_R_CHAN_DONE;
          r_data_out  <= '0;
          r_pulse_out <= 1'b1;
        end
        default: begin
          r_state     <= c_IDLE;
          r_msg_out   <= '0;
          r_addr_out  <= '0;
          r_data_out  <= '0;
          r_pulse_out <= 1'b0;
        end
      endcase
    end
  end

  assign bus.cpu_msg_out     = r_msg_out;
  assign bus.addr_out        = r_addr_out;
  assign bus.data_out        = r_data_out;
  assign bus.cpu_msg_pulse_o = r_pulse_out;
  assign bus.chan_full       = w_full;
  assign bus.fifo_count      = r_count;
  assign bus.ovf_cnt         = r_ovf;

endmodule

`default_nettype wire

// File: tb/tb_chan_responder.sv
// ============================================================================
// Module  : tb_chan_responder
// Brief   : Directed self-checking bench for chan_responder (DEPTH = 4).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

`ifndef CPU_MSG_SIZE0
`define CPU_MSG_SIZE0 3
`endif
`ifndef ADDR_SIZE0
`define ADDR_SIZE0 7
`endif
`ifndef DATA_SIZE0
`define DATA_SIZE0 7
`endif
`ifndef CPU_R_CHAN_SET
`define CPU_R_CHAN_SET 4'd5
`endif
`ifndef CPU_R_CHAN_DONE
`define CPU_R_CHAN_DONE 4'd6
`endif

module tb_chan_responder;

  localparam int DEPTH = 4;
  localparam logic [31:0] c_SET  = 32'(`CPU_R_CHAN_SET);
  localparam logic [31:0] c_DONE = 32'(`CPU_R_CHAN_DONE);

  logic clk = 1'b1;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_err = 0;

  chan_responder_if #(.DEPTH(DEPTH)) bus ();

  chan_responder #(.DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic [31:0] msg, input logic [31:0] addr,
                         input logic [31:0] data, input logic [31:0] pulse);
    chk({tag, ".msg"},   32'(bus.cpu_msg_out),     msg);
    chk({tag, ".addr"},  32'(bus.addr_out),        addr);
    chk({tag, ".data"},  32'(bus.data_out),        data);
    chk({tag, ".pulse"}, 32'(bus.cpu_msg_pulse_o), pulse);
  endtask

  task automatic chk_cnt(input string tag, input logic [31:0] cnt, input logic [31:0] full,
                         input logic [31:0] ovf);
    chk({tag, ".count"}, 32'(bus.fifo_count), cnt);
    chk({tag, ".full"},  32'(bus.chan_full),  full);
    chk({tag, ".ovf"},   32'(bus.ovf_cnt),    ovf);
  endtask

  // One falling edge, then settle before looking or driving
  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic drive(input logic p, input logic [31:0] msg, input logic [31:0] a,
                       input logic [31:0] d);
    bus.cpu_msg_pulse = p;
    bus.cpu_msg_in    = msg[`CPU_MSG_SIZE0:0];
    bus.addr_in       = a[`ADDR_SIZE0:0];
    bus.data_in       = d[`DATA_SIZE0:0];
  endtask

  initial begin
    drive(1'b0, 0, 0, 0);
    bus.is_bus_busy = 1'b0;
    bus.disp_online = 1'b1;

    // ---- Reset state
    step();
    step();
    chk_out("rst", 0, 0, 0, 0);
    chk_cnt("rst", 0, 0, 0);
    rst = 1'b0;

    // ---- Single write: SET, then DONE, then idle
    drive(1'b1, c_SET, 32'h10, 32'h55);
    step();
    chk_out("single.push", 0, 0, 0, 0);
    chk_cnt("single.push", 1, 0, 0);
    drive(1'b0, 0, 0, 0);
    step();
    chk_out("single.send", c_SET, 32'h10, 32'h55, 1);
    chk_cnt("single.send", 0, 0, 0);
    step();
    chk_out("single.done", c_DONE, 32'h10, 0, 1);
    step();
    chk_out("single.idle", 0, 0, 0, 0);

    // ---- Filtering
    drive(1'b1, c_DONE, 32'h03, 32'h04);
    step();
    chk_cnt("filt.done", 0, 0, 0);
    drive(1'b1, 32'h2, 32'h03, 32'h04);
    step();
    chk_cnt("filt.other", 0, 0, 0);
    drive(1'b0, c_SET, 32'h03, 32'h04);
    step();
    chk_cnt("filt.nopulse", 0, 0, 0);
    drive(1'b0, 0, 0, 0);
    step();
    chk_out("filt.noout", 0, 0, 0, 0);

    // ---- Gating by is_bus_busy
    bus.is_bus_busy = 1'b1;
    drive(1'b1, c_SET, 32'h20, 32'h21);
    step();
    drive(1'b0, 0, 0, 0);
    for (int i = 0; i < 10; i++) begin
      step();
      chk("busy.hold.pulse", 32'(bus.cpu_msg_pulse_o), 0);
    end
    chk_cnt("busy.hold", 1, 0, 0);
    bus.is_bus_busy = 1'b0;
    step();
    chk_out("busy.send", c_SET, 32'h20, 32'h21, 1);
    step();
    chk_out("busy.done", c_DONE, 32'h20, 0, 1);
    step();
    chk_out("busy.idle", 0, 0, 0, 0);

    // ---- Gating by disp_online
    bus.disp_online = 1'b0;
    drive(1'b1, c_SET, 32'h30, 32'h31);
    step();
    drive(1'b0, 0, 0, 0);
    for (int i = 0; i < 10; i++) begin
      step();
      chk("offl.hold.pulse", 32'(bus.cpu_msg_pulse_o), 0);
    end
    bus.disp_online = 1'b1;
    step();
    chk_out("offl.send", c_SET, 32'h30, 32'h31, 1);
    step();
    step();
    chk_out("offl.idle", 0, 0, 0, 0);

    // ---- Overflow: five SETs while busy, fifth is dropped
    bus.is_bus_busy = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      drive(1'b1, c_SET, 32'(k), 32'(k * 17));
      step();
    end
    drive(1'b0, 0, 0, 0);
    chk_cnt("ovf.full", 4, 1, 1);
    bus.is_bus_busy = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      step();
      chk_out("ovf.send", c_SET, 32'(k), 32'(k * 17), 1);
      step();
      chk_out("ovf.done", c_DONE, 32'(k), 0, 1);
      step();
      chk_out("ovf.idle", 0, 0, 0, 0);
    end
    chk_cnt("ovf.drained", 0, 0, 1);

    // ---- Simultaneous push and pop, pointers past the wrap point
    bus.is_bus_busy = 1'b1;
    drive(1'b1, c_SET, 32'h40, 32'h41);
    step();
    drive(1'b1, c_SET, 32'h42, 32'h43);
    step();
    chk_cnt("simul.pre", 2, 0, 1);
    bus.is_bus_busy = 1'b0;
    drive(1'b1, c_SET, 32'h44, 32'h45);
    step();
    drive(1'b0, 0, 0, 0);
    chk_out("simul.send0", c_SET, 32'h40, 32'h41, 1);
    chk_cnt("simul.same", 2, 0, 1);
    step();
    chk_out("simul.done0", c_DONE, 32'h40, 0, 1);
    step();
    step();
    chk_out("simul.send1", c_SET, 32'h42, 32'h43, 1);
    chk_cnt("simul.cnt1", 1, 0, 1);
    step();
    step();
    step();
    chk_out("simul.send2", c_SET, 32'h44, 32'h45, 1);
    chk_cnt("simul.cnt2", 0, 0, 1);
    step();
    step();
    chk_out("simul.idle", 0, 0, 0, 0);

    // ---- Reset in the middle of DONE
    bus.is_bus_busy = 1'b1;
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, c_SET, 32'h50 + 32'(2 * k), 32'h51 + 32'(2 * k));
      step();
    end
    drive(1'b0, 0, 0, 0);
    bus.is_bus_busy = 1'b0;
    step();
    chk_out("rstmid.send", c_SET, 32'h50, 32'h51, 1);
    step();
    chk_out("rstmid.done", c_DONE, 32'h50, 0, 1);
    chk_cnt("rstmid.pre", 2, 0, 1);
    rst = 1'b1;
    #1;
    chk_out("rstmid.async", 0, 0, 0, 0);
    chk_cnt("rstmid.async", 0, 0, 0);
    step();
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step();
      chk("rstmid.quiet.pulse", 32'(bus.cpu_msg_pulse_o), 0);
    end
    chk_cnt("rstmid.quiet", 0, 0, 0);

    // ---- Dropped-write counter saturates at 255
    bus.is_bus_busy = 1'b1;
    drive(1'b1, c_SET, 32'h77, 32'h88);
    for (int i = 0; i < 4 + 260; i++) begin
      step();
    end
    drive(1'b0, 0, 0, 0);
    chk_cnt("sat", 4, 1, 255);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
